alu_rr_arbiter: RTL and testbench

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/alu_arb_pkg.sv | 26 ++
 rtl/alu_rr_arbiter_rr_pick.sv | 31 +++
 rtl/alu_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg -- shared types and constants for the ALU round-robin arbiter.
//   state_t        : arbiter FSM state {IDLE, OWNED}
//   NUM_REQ        : number of requesters sharing the ALU (4)
//   IDX_W          : width of a requester index (2)
//   TIMEOUT_CYCLES : watchdog limit in OWNED cycles (15), used only when
//                    ALU_ARB_WATCHDOG_EN is defined
package alu_arb_pkg;

  localparam int NUM_REQ        = 4;
  localparam int IDX_W          = 2;
  localparam int WD_W           = 4;
  localparam int TIMEOUT_CYCLES = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin search.
//   req   [3:0] : request vector
//   ptr   [1:0] : index where the search starts (searches upward, wraps 3->0)
//   valid       : at least one request bit set
//   idx   [1:0] : first set request at or after ptr
module rr_pick
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter -- round-robin arbiter for four requesters sharing one ALU
// through a 4:1 mux.
//   clk            : rising-edge clock
//   reset          : synchronous, active-high
//   req   [3:0]    : per-requester access request (a, b, c, d)
//   done           : 1-cycle pulse, shared ALU finished the current operation
//   grant [3:0]    : registered one-hot grant, zero when nobody owns the ALU
//   select1/2      : registered mux select {MSB,LSB} = owner index, 00 in IDLE
//   busy           : a grant is held
//   timeout        : 1-cycle pulse when the watchdog revokes a grant
//   state          : debug view of the FSM state
//   ptr   [1:0]    : debug view of the round-robin start pointer
// Optional feature: define ALU_ARB_WATCHDOG_EN to add a 4-bit watchdog that
// revokes a grant held for TIMEOUT_CYCLES without release. Without it the
// grant holds indefinitely and timeout is constant 0.
//
// Handshake: a requester owns the ALU from the cycle its grant bit is high
// until the edge after it drops req or done pulses; every release is followed
// by one idle cycle with grant=0 before the next owner is chosen.
module alu_rr_arbiter
  import alu_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               select1,
  output logic               select2,
  output logic               busy,
  output logic               timeout,
  output state_t             state,
  output logic [IDX_W-1:0]   ptr
);

  state_t             state_d;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   owner_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               select1_d;
  logic               select2_d;
  logic               busy_d;
  logic               timeout_d;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               release_evt;
  logic               wd_expire;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // done and a dropped owner request in the same cycle are one release.
  assign release_evt = done || !req[owner_q];

`ifdef ALU_ARB_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt_q;
  logic [WD_W-1:0] wd_cnt_d;

  assign wd_expire = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    owner_d   = owner_q;
    grant_d   = grant;
    select1_d = select1;
    select2_d = select2;
    busy_d    = busy;
    timeout_d = 1'b0;
`ifdef ALU_ARB_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
`endif
    case (state)
      IDLE: begin
        grant_d   = '0;
        select1_d = 1'b0;
        select2_d = 1'b0;
        busy_d    = 1'b0;
        if (pick_valid) begin
          state_d   = OWNED;
          owner_d   = pick_idx;
          grant_d   = idx_to_onehot(pick_idx);
          select1_d = pick_idx[1];
          select2_d = pick_idx[0];
          busy_d    = 1'b1;
`ifdef ALU_ARB_WATCHDOG_EN
          wd_cnt_d  = '0;
`endif
        end
      end
      OWNED: begin
        if (release_evt || wd_expire) begin
          state_d   = IDLE;
          grant_d   = '0;
          select1_d = 1'b0;
          select2_d = 1'b0;
          busy_d    = 1'b0;
          ptr_d     = owner_q + IDX_W'(1);
          // A normal release on the limit cycle wins: no timeout pulse.
          timeout_d = wd_expire && !release_evt;
        end else begin
`ifdef ALU_ARB_WATCHDOG_EN
          wd_cnt_d  = wd_cnt_q + WD_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner_q <= '0;
      grant   <= '0;
      select1 <= 1'b0;
      select2 <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      owner_q <= owner_d;
      grant   <= grant_d;
      select1 <= select1_d;
      select2 <= select2_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter -- self-checking bench for alu_rr_arbiter.
// Each step drives inputs just after a rising edge, pushes the expected
// post-edge output vector, then compares it 1 time unit after the next edge.
// Vector layout: {state, grant[3:0], select1, select2, busy, timeout, ptr[1:0]}.
module tb_alu_rr_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic         done = 1'b0;
  logic [3:0]   grant;
  logic         select1;
  logic         select2;
  logic         busy;
  logic         timeout;
  state_t       state;
  logic [1:0]   ptr;

  logic [W-1:0] exp_q[$];
  int           compared = 0;
  int           mismatched = 0;

  // reference model state for the random phase
  logic         m_owned;
  logic [1:0]   m_owner;
  logic [1:0]   m_ptr;
  int           m_cnt;
  logic         m_t;

  alu_rr_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .select1 (select1),
    .select2 (select2),
    .busy    (busy),
    .timeout (timeout),
    .state   (state),
    .ptr     (ptr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [3:0] g, input logic [1:0] p, input logic t);
    logic [1:0] sel;
    case (g)
      4'b0010: sel = 2'd1;
      4'b0100: sel = 2'd2;
      4'b1000: sel = 2'd3;
      default: sel = 2'd0;
    endcase
    return {(g != 4'b0000), g, sel, (g != 4'b0000), t, p};
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    obs  = {state, grant, select1, select2, busy, timeout, ptr};
    expv = exp_q.pop_front();
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // driver: apply inputs for one cycle and score the resulting outputs
  task automatic step(input logic r, input logic [3:0] q, input logic d,
                      input logic [W-1:0] e, input string tag);
    reset = r;
    req   = q;
    done  = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // independent behavioural model of one clock edge
  task automatic model(input logic r, input logic [3:0] q, input logic d,
                       output logic [W-1:0] e);
    logic       rel;
    logic       wd;
    logic       found;
    logic [1:0] c;
    m_t = 1'b0;
    if (r) begin
      m_owned = 1'b0;
      m_owner = 2'd0;
      m_ptr   = 2'd0;
      m_cnt   = 0;
    end else if (!m_owned) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = m_ptr + 2'(k);
        if (!found && q[c]) begin
          found   = 1'b1;
          m_owned = 1'b1;
          m_owner = c;
          m_cnt   = 0;
        end
      end
    end else begin
      rel = d || !q[m_owner];
`ifdef ALU_ARB_WATCHDOG_EN
      wd = (m_cnt == 15);
`else
      wd = 1'b0;
`endif
      if (rel || wd) begin
        m_owned = 1'b0;
        m_ptr   = m_owner + 2'd1;
        m_t     = wd && !rel;
      end else begin
        m_cnt++;
      end
    end
    e = mk(m_owned ? (4'b0001 << m_owner) : 4'b0000, m_ptr, m_t);
  endtask

  initial begin
    logic [3:0]   rq;
    logic         dn;
    logic         rs;
    logic [W-1:0] e;

    // reset, including one that overrides req and done
    step(1'b1, 4'b0000, 1'b0, mk(4'b0000, 2'd0, 1'b0), "reset_state");
    step(1'b1, 4'b1111, 1'b1, mk(4'b0000, 2'd0, 1'b0), "reset_overrides");
    step(1'b0, 4'b0000, 1'b0, mk(4'b0000, 2'd0, 1'b0), "idle_no_req");

    // single request
    step(1'b0, 4'b0100, 1'b0, mk(4'b0100, 2'd0, 1'b0), "single_grant");
    step(1'b0, 4'b0100, 1'b1, mk(4'b0000, 2'd3, 1'b0), "single_done_release");
    step(1'b0, 4'b0000, 1'b1, mk(4'b0000, 2'd3, 1'b0), "done_in_idle_ignored");

    // wrap from ptr=3 and skip
    step(1'b0, 4'b0011, 1'b0, mk(4'b0001, 2'd3, 1'b0), "wrap_grant0");
    step(1'b0, 4'b0011, 1'b0, mk(4'b0001, 2'd3, 1'b0), "wrap_hold0");
    step(1'b0, 4'b0011, 1'b1, mk(4'b0000, 2'd1, 1'b0), "wrap_release0");
    step(1'b0, 4'b0011, 1'b0, mk(4'b0010, 2'd1, 1'b0), "skip_grant1");
    step(1'b0, 4'b1110, 1'b0, mk(4'b0010, 2'd1, 1'b0), "nonowner_change_ignored");

    // owner drops its request without done
    step(1'b0, 4'b0000, 1'b0, mk(4'b0000, 2'd2, 1'b0), "owner_drop");

    // rotation with all requests held
    step(1'b1, 4'b1111, 1'b0, mk(4'b0000, 2'd0, 1'b0), "rot_reset");
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1111, 1'b0, mk(4'b0001 << (k % 4), 2'(k % 4), 1'b0), "rot_grant");
      step(1'b0, 4'b1111, 1'b0, mk(4'b0001 << (k % 4), 2'(k % 4), 1'b0), "rot_hold");
      if (k < 4)
        step(1'b0, 4'b1111, 1'b1, mk(4'b0000, 2'((k + 1) % 4), 1'b0), "rot_bubble");
    end

    // done and owner drop together: single ptr advance
    step(1'b0, 4'b0000, 1'b1, mk(4'b0000, 2'd1, 1'b0), "done_and_drop");

    // mid-operation reset
    step(1'b0, 4'b1000, 1'b0, mk(4'b1000, 2'd1, 1'b0), "grant3");
    step(1'b1, 4'b1000, 1'b1, mk(4'b0000, 2'd0, 1'b0), "midop_reset");
    step(1'b0, 4'b1001, 1'b0, mk(4'b0001, 2'd0, 1'b0), "after_reset_grant0");

    // long hold without done
`ifdef ALU_ARB_WATCHDOG_EN
    for (int i = 1; i <= 15; i++)
      step(1'b0, 4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b0), "wd_hold");
    step(1'b0, 4'b0001, 1'b0, mk(4'b0000, 2'd1, 1'b1), "wd_timeout");
    step(1'b0, 4'b0000, 1'b0, mk(4'b0000, 2'd1, 1'b0), "wd_pulse_end");
`else
    for (int i = 0; i < 100; i++)
      step(1'b0, 4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b0), "hold_no_wd");
    step(1'b0, 4'b0001, 1'b1, mk(4'b0000, 2'd1, 1'b0), "hold_release");
`endif

    // random traffic against the behavioural model
    model(1'b1, 4'b0000, 1'b0, e);
    step(1'b1, 4'b0000, 1'b0, e, "rand_reset");
    for (int i = 0; i < 80; i++) begin
      rq = 4'($urandom_range(0, 15));
      dn = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 30) == 0);
      model(rs, rq, dn, e);
      step(rs, rq, dn, e, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
